// File: rtl/jtkicker_rom_pkg.sv
// Shared constants for the Kicker ROM arbiter: FSM encoding, slot indices, SDRAM width.
package jtkicker_rom_pkg;
  localparam int SDRAM_AW  = 22;
  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam slot_t SLOT_MAIN = 2'd0;
  localparam slot_t SLOT_SND  = 2'd1;
  localparam slot_t SLOT_SCR  = 2'd2;
  localparam slot_t SLOT_OBJ  = 2'd3;

  function automatic slot_t rr_next(input slot_t s);
    return s + 2'd1;
  endfunction
endpackage

// File: rtl/jtkicker_rom_slot.sv
// One-word tagged ROM cache for a single requester; byte or word port selected by BYTE_MODE.
module jtkicker_rom_slot import jtkicker_rom_pkg::*; #(
  parameter int                  AW        = 14,
  parameter bit                  BYTE_MODE = 1'b0,
  parameter logic [SDRAM_AW-1:0] OFF       = '0,
  localparam int                 TW        = BYTE_MODE ? AW - 1 : AW,
  localparam int                 DW        = BYTE_MODE ? 8 : 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  input  logic                clr,
  input  logic                grant,
  input  logic                fill,
  input  logic                abort,
  input  logic [15:0]         din,
  output logic                miss,
  output logic                ok,
  output logic [DW-1:0]       data,
  output logic [SDRAM_AW-1:0] waddr
);
  logic [15:0]   cache_q, cache_d;
  logic [TW-1:0] tag_q, tag_d, ptag_q, ptag_d, tag_cur;
  logic          valid_q, valid_d, hit;

  // The word tag doubles as the SDRAM word index for both port kinds.
  assign tag_cur = addr[AW-1:AW-TW];
  assign waddr   = OFF + SDRAM_AW'(tag_cur);
  assign hit     = valid_q & (tag_q == tag_cur);
  assign ok      = cs & hit;
  assign miss    = cs & ~hit;

  always_comb begin
    cache_d = cache_q;
    tag_d   = tag_q;
    ptag_d  = ptag_q;
    valid_d = valid_q;
    if (grant) ptag_d = tag_cur;
    if (fill) begin
      cache_d = din;
      tag_d   = ptag_q;
      valid_d = ~abort;
    end
    if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q <= '0;
      tag_q   <= '0;
      ptag_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cache_q <= cache_d;
      tag_q   <= tag_d;
      ptag_q  <= ptag_d;
      valid_q <= valid_d;
    end
  end

  generate
    if (BYTE_MODE) begin : g_byte
      assign data = addr[0] ? cache_q[15:8] : cache_q[7:0];
    end else begin : g_word
      assign data = cache_q;
    end
  endgenerate
endmodule

// File: rtl/jtkicker_rom_arb.sv
// Round-robin sharing of SDRAM bank 0 among four cached ROM ports of a Kicker-family top.
// Define JTKICKER_ROMARB_STATS_EN to build per-slot saturating miss counters on `stats`.
module jtkicker_rom_arb import jtkicker_rom_pkg::*; #(
  parameter int                  AW0  = 16,
  parameter int                  AW1  = 13,
  parameter int                  AW2  = 14,
  parameter int                  AW3  = 14,
  parameter logic [SDRAM_AW-1:0] OFF0 = 22'h0,
  parameter logic [SDRAM_AW-1:0] OFF1 = 22'h0,
  parameter logic [SDRAM_AW-1:0] OFF2 = 22'h0,
  parameter logic [SDRAM_AW-1:0] OFF3 = 22'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                s0_cs,
  input  logic [AW0-1:0]      s0_addr,
  output logic [7:0]          s0_data,
  output logic                s0_ok,
  input  logic                s1_cs,
  input  logic [AW1-1:0]      s1_addr,
  output logic [7:0]          s1_data,
  output logic                s1_ok,
  input  logic                s2_cs,
  input  logic [AW2-1:0]      s2_addr,
  output logic [15:0]         s2_data,
  output logic                s2_ok,
  input  logic                s3_cs,
  input  logic [AW3-1:0]      s3_addr,
  output logic [15:0]         s3_data,
  output logic                s3_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_rd,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [15:0]         sdram_dout,
  input  logic [1:0]          stats_sel,
  output logic [15:0]         stats
);
  logic [NUM_SLOTS-1:0]               miss, grant, fill;
  logic [NUM_SLOTS-1:0][SDRAM_AW-1:0] waddr;
  logic [1:0]                         state_q, state_d;
  slot_t                              ptr_q, ptr_d, gnt_q, gnt_d, sel, idx;
  logic                               rd_q, rd_d, abort_q, abort_d, found;
  logic [SDRAM_AW-1:0]                addr_q, addr_d;

  jtkicker_rom_slot #(.AW(AW0), .BYTE_MODE(1'b1), .OFF(OFF0)) u_slot0 (
    .clk, .rst_n, .cs(s0_cs), .addr(s0_addr), .clr(downloading),
    .grant(grant[SLOT_MAIN]), .fill(fill[SLOT_MAIN]), .abort(abort_q), .din(sdram_dout),
    .miss(miss[SLOT_MAIN]), .ok(s0_ok), .data(s0_data), .waddr(waddr[SLOT_MAIN]));

  jtkicker_rom_slot #(.AW(AW1), .BYTE_MODE(1'b1), .OFF(OFF1)) u_slot1 (
    .clk, .rst_n, .cs(s1_cs), .addr(s1_addr), .clr(downloading),
    .grant(grant[SLOT_SND]), .fill(fill[SLOT_SND]), .abort(abort_q), .din(sdram_dout),
    .miss(miss[SLOT_SND]), .ok(s1_ok), .data(s1_data), .waddr(waddr[SLOT_SND]));

  jtkicker_rom_slot #(.AW(AW2), .BYTE_MODE(1'b0), .OFF(OFF2)) u_slot2 (
    .clk, .rst_n, .cs(s2_cs), .addr(s2_addr), .clr(downloading),
    .grant(grant[SLOT_SCR]), .fill(fill[SLOT_SCR]), .abort(abort_q), .din(sdram_dout),
    .miss(miss[SLOT_SCR]), .ok(s2_ok), .data(s2_data), .waddr(waddr[SLOT_SCR]));

  jtkicker_rom_slot #(.AW(AW3), .BYTE_MODE(1'b0), .OFF(OFF3)) u_slot3 (
    .clk, .rst_n, .cs(s3_cs), .addr(s3_addr), .clr(downloading),
    .grant(grant[SLOT_OBJ]), .fill(fill[SLOT_OBJ]), .abort(abort_q), .din(sdram_dout),
    .miss(miss[SLOT_OBJ]), .ok(s3_ok), .data(s3_data), .waddr(waddr[SLOT_OBJ]));

  assign sdram_rd   = rd_q;
  assign sdram_addr = addr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    abort_d = abort_q;
    grant   = '0;
    fill    = '0;
    found   = 1'b0;
    sel     = ptr_q;
    idx     = ptr_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = ptr_q + slot_t'(i);
      if (!found && miss[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (found && !downloading) begin
          grant[sel] = 1'b1;
          gnt_d      = sel;
          addr_d     = waddr[sel];
          rd_d       = 1'b1;
          ptr_d      = rr_next(sel);
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          rd_d = 1'b0;
          // ack and rdy together: accept and fill in the same cycle
          if (sdram_rdy) begin
            fill[gnt_q] = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram_rdy) begin
          fill[gnt_q] = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (downloading && state_q != ST_IDLE) abort_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= SLOT_MAIN;
      gnt_q   <= SLOT_MAIN;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
    end
  end

`ifdef JTKICKER_ROMARB_STATS_EN
  logic [NUM_SLOTS-1:0][15:0] cnt_q, cnt_d;
  logic                       dl_q, dl_d;

  always_comb begin
    cnt_d = cnt_q;
    dl_d  = downloading;
    if (downloading && !dl_q) begin
      cnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dl_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dl_q  <= dl_d;
    end
  end

  assign stats = cnt_q[stats_sel];
`else
  logic unused_stats;
  assign unused_stats = ^stats_sel;
  assign stats        = '0;
`endif
endmodule

// File: tb/tb_jtkicker_rom_arb.sv
// Scoreboarded bench for jtkicker_rom_arb: directed handshake cases plus randomized requesters.
module tb_jtkicker_rom_arb;
  logic        clk = 1'b0;
  logic        rst_n, downloading;
  logic        s0_cs, s1_cs, s2_cs, s3_cs;
  logic [15:0] s0_addr;
  logic [12:0] s1_addr;
  logic [13:0] s2_addr, s3_addr;
  logic [7:0]  s0_data, s1_data;
  logic [15:0] s2_data, s3_data;
  logic        s0_ok, s1_ok, s2_ok, s3_ok;
  logic [21:0] sdram_addr;
  logic        sdram_rd, sdram_ack, sdram_rdy;
  logic [15:0] sdram_dout;
  logic [1:0]  stats_sel;
  logic [15:0] stats;

  logic        rsp_en, rsp_rnd, r_ack, r_rdy, m_ack, m_rdy;
  logic [15:0] r_dout, m_dout;
  int          total, bad, req_cnt;
  logic [15:0] expq [4][$];
  int          gexp [$];
  bit          pend [4];

  assign sdram_ack  = rsp_en ? r_ack  : m_ack;
  assign sdram_rdy  = rsp_en ? r_rdy  : m_rdy;
  assign sdram_dout = rsp_en ? r_dout : m_dout;

  always #5 clk = ~clk;

  jtkicker_rom_arb #(.OFF0(22'h0), .OFF1(22'h08000), .OFF2(22'h10000), .OFF3(22'h20000)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .s0_cs(s0_cs), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ok(s0_ok),
    .s1_cs(s1_cs), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ok(s1_ok),
    .s2_cs(s2_cs), .s2_addr(s2_addr), .s2_data(s2_data), .s2_ok(s2_ok),
    .s3_cs(s3_cs), .s3_addr(s3_addr), .s3_data(s3_data), .s3_ok(s3_ok),
    .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout),
    .stats_sel(stats_sel), .stats(stats));

  // ---------------- reference model ----------------
  function automatic logic [21:0] off_of(input int s);
    case (s)
      0: return 22'h0;
      1: return 22'h08000;
      2: return 22'h10000;
      default: return 22'h20000;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(input int s);
    case (s)
      0: return 16'hFFFF;
      1: return 16'h1FFF;
      default: return 16'h3FFF;
    endcase
  endfunction

  function automatic logic [15:0] memf(input logic [21:0] a);
    logic [15:0] h;
    h = a[15:0] * 16'h2F1B;
    return h ^ {a[21:16], 4'h0, a[21:16]};
  endfunction

  function automatic logic [15:0] exp_data(input int s, input logic [15:0] a);
    logic [21:0] w;
    logic [15:0] word;
    w    = off_of(s) + ((s < 2) ? 22'(a >> 1) : 22'(a));
    word = memf(w);
    if (s < 2) return {8'h00, a[0] ? word[15:8] : word[7:0]};
    return word;
  endfunction

  function automatic int slot_of(input logic [21:0] a);
    if (a >= 22'h20000) return 3;
    if (a >= 22'h10000) return 2;
    if (a >= 22'h08000) return 1;
    return 0;
  endfunction

  function automatic logic get_ok(input int s);
    case (s)
      0: return s0_ok;
      1: return s1_ok;
      2: return s2_ok;
      default: return s3_ok;
    endcase
  endfunction

  function automatic logic [15:0] get_data(input int s);
    case (s)
      0: return {8'h00, s0_data};
      1: return {8'h00, s1_data};
      2: return s2_data;
      default: return s3_data;
    endcase
  endfunction

  task automatic drive(input int s, input logic c, input logic [15:0] a);
    case (s)
      0: begin s0_cs = c; s0_addr = a; end
      1: begin s1_cs = c; s1_addr = a[12:0]; end
      2: begin s2_cs = c; s2_addr = a[13:0]; end
      default: begin s3_cs = c; s3_addr = a[13:0]; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ok(input int s, input string name);
    int t;
    t = 0;
    while (!get_ok(s) && t < 200) begin @(negedge clk); #1; t++; end
    chk(name, get_ok(s), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; downloading = 1'b0; m_ack = 1'b0; m_rdy = 1'b0;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- SDRAM responder + grant-order scoreboard ----------------
  initial begin
    logic [21:0] a;
    int          ad, rdl, g;
    bit          same;
    r_ack = 1'b0; r_rdy = 1'b0; r_dout = 16'h0;
    forever begin
      @(negedge clk);
      if (rsp_en && sdram_rd === 1'b1) begin
        a = sdram_addr;
        req_cnt++;
        if (gexp.size() > 0) begin
          g = gexp.pop_front();
          chk("grant_order", 32'(slot_of(a)), 32'(g));
        end
        if (rsp_rnd) begin
          ad = $urandom_range(0, 3); rdl = $urandom_range(0, 3); same = ($urandom_range(0, 3) == 0);
        end else begin
          ad = 1; rdl = 1; same = 1'b0;
        end
        repeat (ad) @(negedge clk);
        chk("req_hold", {9'h0, sdram_rd, sdram_addr}, {9'h0, 1'b1, a});
        if (same) begin
          r_ack = 1'b1; r_rdy = 1'b1; r_dout = memf(a);
          @(negedge clk);
          r_ack = 1'b0; r_rdy = 1'b0;
        end else begin
          r_ack = 1'b1;
          @(negedge clk);
          r_ack = 1'b0;
          repeat (rdl) @(negedge clk);
          r_rdy = 1'b1; r_dout = memf(a);
          @(negedge clk);
          r_rdy = 1'b0;
        end
      end
    end
  end

  // ---------------- data monitor ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk); #1;
      for (int s = 0; s < 4; s++) begin
        if (pend[s] && get_ok(s)) begin
          e = expq[s].pop_front();
          total++;
          if (get_data(s) !== e) begin
            bad++;
            $display("FAIL data_slot%0d actual=%0h required=%0h", s, get_data(s), e);
          end
          pend[s] = 1'b0;
        end
      end
    end
  end

  task automatic run_slot(input int s, input int n);
    logic [15:0] a, last;
    int          t;
    last = 16'h0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = ($urandom_range(0, 2) == 0) ? 16'($urandom) : (last ^ 16'($urandom_range(0, 3)));
      a = a & mask_of(s);
      last = a;
      drive(s, 1'b1, a);
      expq[s].push_back(exp_data(s, a));
      pend[s] = 1'b1;
      t = 0;
      while (pend[s] && t < 400) begin @(negedge clk); t++; end
      if (pend[s]) begin
        total++; bad++;
        $display("FAIL timeout_slot%0d actual=no_ok required=ok", s);
        pend[s] = 1'b0;
        expq[s].delete();
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(s, 1'b0, a);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    @(negedge clk);
    drive(s, 1'b0, 16'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    total = 0; bad = 0; req_cnt = 0;
    rsp_en = 1'b0; rsp_rnd = 1'b0; m_dout = 16'h0; stats_sel = 2'd0;
    for (int s = 0; s < 4; s++) pend[s] = 1'b0;
    rst_n = 1'b0; downloading = 1'b0; m_ack = 1'b0; m_rdy = 1'b0;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", sdram_rd, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_ok", {s0_ok, s1_ok, s2_ok, s3_ok}, 0);
    chk("rst_data", {s0_data, s1_data, s2_data, s3_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // byte port fill, latency and second-byte hit
    drive(0, 1'b1, 16'h0003);
    #1 chk("t1_no_ok", s0_ok, 0);
    @(negedge clk); #1;
    chk("t1_rd", sdram_rd, 1);
    chk("t1_addr", sdram_addr, 22'h1);
    m_ack = 1'b1;
    @(negedge clk); m_ack = 1'b0; #1;
    chk("t1_rd_drop", sdram_rd, 0);
    @(negedge clk); m_rdy = 1'b1; m_dout = 16'hA55A; #1;
    chk("t1_ok_early", s0_ok, 0);
    @(negedge clk); m_rdy = 1'b0; #1;
    chk("t1_ok", s0_ok, 1);
    chk("t1_data_hi", s0_data, 8'hA5);
    @(negedge clk); drive(0, 1'b1, 16'h0002); #1;
    chk("t1_ok_lo", s0_ok, 1);
    chk("t1_data_lo", s0_data, 8'h5A);
    repeat (3) begin @(negedge clk); #1; chk("t1_no_new_rd", sdram_rd, 0); end

    // round-robin order from pointer 0
    do_reset();
    rsp_en = 1'b1;
    gexp.push_back(1); gexp.push_back(2); gexp.push_back(3);
    drive(1, 1'b1, 16'h0010); drive(2, 1'b1, 16'h0020); drive(3, 1'b1, 16'h0030);
    #1 wait_ok(1, "t2_s1_ok");
    gexp.push_back(0); gexp.push_back(1);
    drive(1, 1'b1, 16'h0012); drive(0, 1'b1, 16'h0040);
    t = 0;
    while (!(s0_ok && s1_ok && s2_ok && s3_ok) && t < 200) begin @(negedge clk); #1; t++; end
    chk("t2_all_ok", {s0_ok, s1_ok, s2_ok, s3_ok}, 4'hF);
    chk("t2_gexp_empty", gexp.size(), 0);
    chk("t2_s3_data", s3_data, exp_data(3, 16'h0030));
    chk("t2_s1_data", s1_data, exp_data(1, 16'h0012));
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0);
    repeat (6) @(negedge clk);
    rsp_en = 1'b0;

    // top word address with offset, ack+rdy together
    @(negedge clk); drive(2, 1'b1, 16'h3FFF);
    @(negedge clk); #1;
    chk("t3_rd", sdram_rd, 1);
    chk("t3_addr", sdram_addr, 22'h13FFF);
    m_ack = 1'b1; m_rdy = 1'b1; m_dout = 16'hBEEF;
    @(negedge clk); m_ack = 1'b0; m_rdy = 1'b0; #1;
    chk("t3_ok", s2_ok, 1);
    chk("t3_data", s2_data, 16'hBEEF);
    chk("t3_rd_drop", sdram_rd, 0);
    drive(2, 1'b0, 16'h0);

    // download during WAIT aborts the fill and flushes caches
    @(negedge clk); drive(3, 1'b1, 16'h0155);
    @(negedge clk); #1;
    chk("t4_rd", sdram_rd, 1);
    chk("t4_addr", sdram_addr, 22'h20155);
    m_ack = 1'b1;
    @(negedge clk); m_ack = 1'b0; downloading = 1'b1;
    @(negedge clk); m_rdy = 1'b1; m_dout = 16'h1234;
    @(negedge clk); m_rdy = 1'b0; drive(2, 1'b1, 16'h3FFF); #1;
    chk("t4_s3_not_ok", s3_ok, 0);
    chk("t4_s2_flushed", s2_ok, 0);
    repeat (4) begin @(negedge clk); #1; chk("t4_no_rd_dl", sdram_rd, 0); end
    @(negedge clk); downloading = 1'b0; #1;
    chk("t4_after_dl_ok", {s2_ok, s3_ok}, 0);
    @(negedge clk); #1;
    chk("t4_regrant_rd", sdram_rd, 1);
    chk("t4_regrant_addr", sdram_addr, 22'h13FFF);

    // async reset while in REQ
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rd_async", sdram_rd, 0);
    chk("t5_addr_async", sdram_addr, 0);
    chk("t5_ok_async", {s0_ok, s1_ok, s2_ok, s3_ok}, 0);
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t5_idle_rd", sdram_rd, 0);
    drive(1, 1'b1, 16'h0007);
    @(negedge clk); #1;
    chk("t5_restart_rd", sdram_rd, 1);
    chk("t5_restart_addr", sdram_addr, 22'h08003);
    m_ack = 1'b1; m_rdy = 1'b1; m_dout = 16'hC3D2;
    @(negedge clk); m_ack = 1'b0; m_rdy = 1'b0; #1;
    chk("t5_s1_ok", s1_ok, 1);
    chk("t5_s1_data", s1_data, 8'hC3);
    drive(1, 1'b0, 16'h0);

    // miss statistics
    do_reset();
    rsp_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(0, 1'b1, 16'(k * 2 + 16'h100));
      #1 wait_ok(0, "t6_fill");
    end
    drive(0, 1'b0, 16'h0);
    repeat (4) @(negedge clk);
    stats_sel = 2'd0; #1;
`ifdef JTKICKER_ROMARB_STATS_EN
    chk("t6_stats0", stats, 16'd5);
    stats_sel = 2'd1; #1;
    chk("t6_stats1", stats, 16'd0);
`else
    chk("t6_stats_off", stats, 16'd0);
`endif

    // randomized concurrent requesters
    rsp_rnd = 1'b1;
    fork
      run_slot(0, 30);
      run_slot(1, 30);
      run_slot(2, 30);
      run_slot(3, 30);
    join
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
